// File: rtl/div_seq_restoring.sv
// Sequential restoring divider, unsigned or two's-complement, with a start/busy/done handshake.
// One quotient bit per cycle on operand magnitudes, then a sign fix-up cycle.
module div_seq_restoring #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] b_q;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic [WIDTH:0]   a_sh;
  logic             fits;
  logic [WIDTH-1:0] a_sub;

  function automatic logic [WIDTH-1:0] mag(input logic s, input logic [WIDTH-1:0] x);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept = (state == IDLE) && start;

  // Partial remainder is kept below the divisor, so the shifted value needs one
  // extra bit only for the comparison; the difference itself always fits in WIDTH.
  assign a_sh  = {a_q, q_q[WIDTH-1]};
  assign fits  = a_sh >= {1'b0, b_q};
  assign a_sub = a_sh[WIDTH-1:0] - b_q;

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: the datapath registers are reset too, since an aborted operation must
  // leave every visible result cleared, not just the control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      // Handshake outputs trail the control state by one registered cycle.
      busy <= (state != IDLE);
      done <= (state == DONE);

      if (accept) begin
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
          div_zero  <= 1'b1;
        end else begin
          div_zero <= 1'b0;
          a_q      <= '0;
          q_q      <= mag(sgn, dividend);
          b_q      <= mag(sgn, divisor);
          cnt      <= CNT_W'(WIDTH);
          q_neg    <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg    <= sgn && dividend[WIDTH-1];
        end
      end

      if (state == RUN) begin
        a_q <= fits ? a_sub : a_sh[WIDTH-1:0];
        q_q <= {q_q[WIDTH-2:0], fits};
        cnt <= cnt - CNT_W'(1);
      end

      if (state == FIX) begin
        quotient  <= q_neg ? -q_q : q_q;
        remainder <= r_neg ? -a_q : a_q;
      end
    end
  end

endmodule
